sync_fifo_ext: RTL and testbench

SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

---
 rtl/fifo_pkg.sv | 7 +
 rtl/fifo_out_stage.sv | 36 +++
 rtl/sync_fifo_ext.sv | 164 ++++++++++++++++
 tb/tb_sync_fifo_ext.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - output-mode selector constants shared by the FIFO slice
package fifo_pkg;

  localparam int OUT_MODE_COMB = 0;
  localparam int OUT_MODE_REG  = 1;

endpackage

// File: rtl/fifo_out_stage.sv
// rtl/fifo_out_stage.sv - one-entry valid/ready output register for the FIFO head
//   clk, rst            : clock, synchronous active-high reset
//   clr                 : synchronous discard of the held entry (flush)
//   s_tdata/s_tvalid/s_tready : upstream entry offered by storage
//   m_tdata/m_tvalid/m_tready : registered head presented to the consumer
module fifo_out_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready
);

  // Refill in the same cycle the held entry is consumed, so a steady
  // stream of reads sees no bubble.
  assign s_tready = ~m_tvalid | m_tready;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
    end else if (s_tvalid && s_tready) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/sync_fifo_ext.sv
// rtl/sync_fifo_ext.sv - synchronous FIFO with registered status, sticky errors, optional output register
//   clk, rst                 : clock, synchronous active-high reset
//   data_i, wr_valid_i       : write payload and request; wr_ready_o = ~full_o
//   data_o, rd_valid_i       : head entry and consumer accept; rd_ready_o flags a valid head
//   flush_i                  : discard all contents (error flags held)
//   clr_err_i                : clear overflow_o / underflow_o
//   empty_o, full_o, almost_empty_o, almost_full_o, counter_o : registered occupancy status
//   overflow_o, underflow_o  : sticky error flags
module sync_fifo_ext
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int OUT_MODE   = OUT_MODE_COMB,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  input  logic                          rd_valid_i,
  output logic                          rd_ready_o,
  input  logic                          flush_i,
  input  logic                          clr_err_i,
  output logic                          empty_o,
  output logic                          full_o,
  output logic                          almost_empty_o,
  output logic                          almost_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   counter_o,
  output logic                          overflow_o,
  output logic                          underflow_o
);

  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THRESH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_ext: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (OUT_MODE != OUT_MODE_COMB && OUT_MODE != OUT_MODE_REG) begin : g_bad_mode
    $error("sync_fifo_ext: OUT_MODE must be 0 or 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
    $error("sync_fifo_ext: AF_THRESH must lie in 1..FIFO_DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_ext: AE_THRESH must lie in 0..FIFO_DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CNT_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;
  logic [DATA_WIDTH-1:0] mem_head;
  logic                  mem_nonempty;
  logic                  pop_req;
  logic                  mem_pop;
  logic                  wr_hs;
  logic                  rd_hs;
  logic                  ovf_set;
  logic                  udf_set;

  // Flush discards any handshake presented in the same cycle.
  assign wr_hs = wr_valid_i & wr_ready_o & ~flush_i;
  assign rd_hs = rd_valid_i & rd_ready_o & ~flush_i;

  // Storage occupancy from the wrap-bit pointers; in OUT_MODE=1 this excludes
  // the entry held in the output register, while count covers both.
  assign mem_nonempty = (wr_ptr != rd_ptr);
  assign mem_pop      = mem_nonempty & pop_req & ~flush_i;
  assign mem_head     = mem[rd_ptr[ADDR_WIDTH-1:0]];

  if (OUT_MODE == OUT_MODE_REG) begin : g_reg_out
    logic stage_ready;

    fifo_out_stage #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush_i),
      .s_tdata  (mem_head),
      .s_tvalid (mem_nonempty),
      .s_tready (stage_ready),
      .m_tdata  (data_o),
      .m_tvalid (rd_ready_o),
      .m_tready (rd_valid_i)
    );

    // Storage feeds the register whenever it is empty or being read.
    assign pop_req = stage_ready;
  end else begin : g_comb_out
    assign data_o     = mem_head;
    assign rd_ready_o = ~empty_o;
    assign pop_req    = rd_hs;
  end

  assign wr_ready_o = ~full_o;
  assign counter_o  = count;

  always_comb begin
    count_nxt = count;
    case ({wr_hs, rd_hs})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_hs) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_i;
    end
  end

  // Flags are registered from next-state occupancy so they always agree
  // with counter_o in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      empty_o        <= 1'b1;
      full_o         <= 1'b0;
      almost_empty_o <= 1'b1;
      almost_full_o  <= 1'b0;
    end else begin
      if (wr_hs) begin
        wr_ptr <= wr_ptr + CNT_W'(1);
      end
      if (mem_pop) begin
        rd_ptr <= rd_ptr + CNT_W'(1);
      end
      count          <= count_nxt;
      empty_o        <= (count_nxt == '0);
      full_o         <= (count_nxt == FULL_LVL);
      almost_empty_o <= (count_nxt <= AE_LVL);
      almost_full_o  <= (count_nxt >= AF_LVL);
    end
  end

  assign ovf_set = wr_valid_i & full_o  & ~flush_i;
  assign udf_set = rd_valid_i & empty_o & ~flush_i;

  // A set event in the same cycle as clr_err_i wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= ovf_set | (overflow_o  & ~clr_err_i);
      underflow_o <= udf_set | (underflow_o & ~clr_err_i);
    end
  end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb/tb_sync_fifo_ext.sv - scoreboard bench for sync_fifo_ext in both output modes
module tb_sync_fifo_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din  [2];
  logic       wv   [2];
  logic       rv   [2];
  logic       fl   [2];
  logic       ce   [2];
  logic [7:0] dout [2];
  logic       wrdy [2];
  logic       rrdy [2];
  logic       emp  [2];
  logic       ful  [2];
  logic       ae   [2];
  logic       af   [2];
  logic       ovf  [2];
  logic       udf  [2];
  logic [2:0] cnt  [2];

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb [$];

  // {cnt, empty, full, wr_ready, rd_ready, almost_empty, almost_full, overflow, underflow}
  localparam logic [10:0] RST_VEC = {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  sync_fifo_ext #(
    .DATA_WIDTH(8), .FIFO_DEPTH(4), .OUT_MODE(0), .AF_THRESH(3), .AE_THRESH(1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .data_i(din[0]), .wr_valid_i(wv[0]), .wr_ready_o(wrdy[0]),
    .data_o(dout[0]), .rd_valid_i(rv[0]), .rd_ready_o(rrdy[0]), .flush_i(fl[0]),
    .clr_err_i(ce[0]), .empty_o(emp[0]), .full_o(ful[0]), .almost_empty_o(ae[0]),
    .almost_full_o(af[0]), .counter_o(cnt[0]), .overflow_o(ovf[0]), .underflow_o(udf[0])
  );

  sync_fifo_ext #(
    .DATA_WIDTH(8), .FIFO_DEPTH(4), .OUT_MODE(1), .AF_THRESH(3), .AE_THRESH(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .data_i(din[1]), .wr_valid_i(wv[1]), .wr_ready_o(wrdy[1]),
    .data_o(dout[1]), .rd_valid_i(rv[1]), .rd_ready_o(rrdy[1]), .flush_i(fl[1]),
    .clr_err_i(ce[1]), .empty_o(emp[1]), .full_o(ful[1]), .almost_empty_o(ae[1]),
    .almost_full_o(af[1]), .counter_o(cnt[1]), .overflow_o(ovf[1]), .underflow_o(udf[1])
  );

  function automatic logic [10:0] status(int m);
    return {cnt[m], emp[m], ful[m], wrdy[m], rrdy[m], ae[m], af[m], ovf[m], udf[m]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int m = 0; m < 2; m++) begin
      din[m] = '0; wv[m] = 1'b0; rv[m] = 1'b0; fl[m] = 1'b0; ce[m] = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  // Caller guarantees every write is accepted, so each one goes to the scoreboard.
  task automatic write_n(int m, logic [7:0] base, int n);
    for (int i = 0; i < n; i++) begin
      wv[m]  = 1'b1;
      din[m] = 8'(base + 8'(i));
      sb.push_back(din[m]);
      tick();
    end
    wv[m] = 1'b0;
  endtask

  task automatic drain(int m);
    logic [7:0] exp_d;
    rv[m] = 1'b1;
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      if (rrdy[m]) begin
        exp_d = sb.pop_front();
        n_cmp++;
        if (dout[m] !== exp_d) begin
          n_bad++;
          $display("FAIL drain_data m%0d: got %h exp %h", m, dout[m], exp_d);
        end
      end
      tick();
    end
    rv[m] = 1'b0;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout m%0d: got %0d left exp 0", m, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset(int m);
    do_reset();
    n_cmp++;
    if (status(m) !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_state m%0d: got %b exp %b", m, status(m), RST_VEC);
    end
  endtask

  task automatic test_fill_drain(int m);
    do_reset();
    write_n(m, 8'hA0, 4);
    n_cmp++;
    if ({cnt[m], ful[m], wrdy[m]} !== {3'd4, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL fill_full m%0d: got %b exp %b", m, {cnt[m], ful[m], wrdy[m]}, {3'd4, 1'b1, 1'b0});
    end
    wv[m] = 1'b1; din[m] = 8'hEE;
    tick();
    wv[m] = 1'b0;
    n_cmp++;
    if ({cnt[m], ful[m], ovf[m]} !== {3'd4, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL overflow m%0d: got %b exp %b", m, {cnt[m], ful[m], ovf[m]}, {3'd4, 1'b1, 1'b1});
    end
    drain(m);
    n_cmp++;
    if ({cnt[m], emp[m]} !== {3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL drained_empty m%0d: got %b exp %b", m, {cnt[m], emp[m]}, {3'd0, 1'b1});
    end
  endtask

  task automatic test_latency(int m);
    logic [7:0] exp_d;
    do_reset();
    wv[m] = 1'b1; din[m] = 8'h55;
    tick();
    wv[m] = 1'b0;
    n_cmp++;
    if ({rrdy[m], cnt[m]} !== {(m == 0), 3'd1}) begin
      n_bad++;
      $display("FAIL latency_n1 m%0d: got %b exp %b", m, {rrdy[m], cnt[m]}, {(m == 0), 3'd1});
    end
    if (m == 1) tick();
    n_cmp++;
    if ({rrdy[m], dout[m]} !== {1'b1, 8'h55}) begin
      n_bad++;
      $display("FAIL latency_head m%0d: got %h exp %h", m, {rrdy[m], dout[m]}, {1'b1, 8'h55});
    end
    rv[m] = 1'b1;
    tick();
    rv[m] = 1'b0;
    sb.delete();
    write_n(m, 8'hB0, 3);
    tick();
    tick();
    rv[m] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_d = sb.pop_front();
      n_cmp++;
      if ({rrdy[m], dout[m]} !== {1'b1, exp_d}) begin
        n_bad++;
        $display("FAIL no_bubble m%0d: got %h exp %h", m, {rrdy[m], dout[m]}, {1'b1, exp_d});
      end
      tick();
    end
    rv[m] = 1'b0;
    n_cmp++;
    if (emp[m] !== 1'b1) begin
      n_bad++;
      $display("FAIL bubble_empty m%0d: got %b exp 1", m, emp[m]);
    end
  endtask

  task automatic test_full_rw(int m);
    logic [7:0] exp_d;
    do_reset();
    write_n(m, 8'hC0, 4);
    wv[m] = 1'b1; rv[m] = 1'b1; din[m] = 8'hDD;
    exp_d = sb.pop_front();
    n_cmp++;
    if ({rrdy[m], dout[m]} !== {1'b1, exp_d}) begin
      n_bad++;
      $display("FAIL full_rw_head m%0d: got %h exp %h", m, {rrdy[m], dout[m]}, {1'b1, exp_d});
    end
    tick();
    n_cmp++;
    if ({cnt[m], ful[m], ovf[m]} !== {3'd3, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL full_rw_cnt m%0d: got %b exp %b", m, {cnt[m], ful[m], ovf[m]}, {3'd3, 1'b0, 1'b1});
    end
    for (int i = 0; i < 10; i++) begin
      din[m] = 8'(8'h10 + 8'(i));
      exp_d = sb.pop_front();
      n_cmp++;
      if ({rrdy[m], dout[m]} !== {1'b1, exp_d}) begin
        n_bad++;
        $display("FAIL wrap_data m%0d: got %h exp %h", m, {rrdy[m], dout[m]}, {1'b1, exp_d});
      end
      sb.push_back(din[m]);
      tick();
      n_cmp++;
      if (cnt[m] !== 3'd3) begin
        n_bad++;
        $display("FAIL wrap_cnt m%0d: got %0d exp 3", m, cnt[m]);
      end
    end
    wv[m] = 1'b0; rv[m] = 1'b0;
    drain(m);
  endtask

  task automatic test_thresholds(int m);
    logic [6:0] exp_v;
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      exp_v = {3'(k), (k == 0), (k == 4), (k <= 1), (k >= 3)};
      n_cmp++;
      if ({cnt[m], emp[m], ful[m], ae[m], af[m]} !== exp_v) begin
        n_bad++;
        $display("FAIL thresholds m%0d k%0d: got %b exp %b", m, k, {cnt[m], emp[m], ful[m], ae[m], af[m]}, exp_v);
      end
      if (k < 4) begin
        wv[m] = 1'b1; din[m] = 8'(k);
        tick();
        wv[m] = 1'b0;
      end
    end
  endtask

  task automatic test_flush(int m);
    logic [10:0] exp_v;
    do_reset();
    write_n(m, 8'h60, 4);
    wv[m] = 1'b1; din[m] = 8'hEE;
    tick();
    wv[m] = 1'b0;
    rv[m] = 1'b1;
    void'(sb.pop_front());
    tick();
    rv[m] = 1'b0;
    fl[m] = 1'b1; wv[m] = 1'b1; din[m] = 8'h77;
    tick();
    fl[m] = 1'b0; wv[m] = 1'b0;
    sb.delete();
    exp_v = {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (status(m) !== exp_v) begin
      n_bad++;
      $display("FAIL flush_state m%0d: got %b exp %b", m, status(m), exp_v);
    end
    fl[m] = 1'b1; rv[m] = 1'b1;
    tick();
    fl[m] = 1'b0; rv[m] = 1'b0;
    n_cmp++;
    if ({udf[m], ovf[m]} !== 2'b01) begin
      n_bad++;
      $display("FAIL flush_no_err m%0d: got %b exp 01", m, {udf[m], ovf[m]});
    end
    write_n(m, 8'h33, 1);
    drain(m);
    n_cmp++;
    if ({cnt[m], emp[m]} !== {3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL flush_discard m%0d: got %b exp %b", m, {cnt[m], emp[m]}, {3'd0, 1'b1});
    end
    ce[m] = 1'b1;
    tick();
    ce[m] = 1'b0;
    n_cmp++;
    if (ovf[m] !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_err m%0d: got %b exp 0", m, ovf[m]);
    end
    write_n(m, 8'h40, 4);
    ce[m] = 1'b1; wv[m] = 1'b1; din[m] = 8'hEE;
    tick();
    wv[m] = 1'b0;
    n_cmp++;
    if (ovf[m] !== 1'b1) begin
      n_bad++;
      $display("FAIL set_wins_clr m%0d: got %b exp 1", m, ovf[m]);
    end
    tick();
    ce[m] = 1'b0;
    n_cmp++;
    if (ovf[m] !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_after_set m%0d: got %b exp 0", m, ovf[m]);
    end
  endtask

  task automatic test_reset_midburst(int m);
    do_reset();
    write_n(m, 8'h90, 2);
    wv[m] = 1'b1; rv[m] = 1'b1; din[m] = 8'hAA; rst = 1'b1;
    tick();
    rst = 1'b0; wv[m] = 1'b0; rv[m] = 1'b0;
    sb.delete();
    n_cmp++;
    if (status(m) !== RST_VEC) begin
      n_bad++;
      $display("FAIL midburst_reset m%0d: got %b exp %b", m, status(m), RST_VEC);
    end
    if (m == 1) begin
      n_cmp++;
      if (dout[m] !== 8'h00) begin
        n_bad++;
        $display("FAIL out_reg_reset m%0d: got %h exp 00", m, dout[m]);
      end
    end
    rv[m] = 1'b1;
    tick();
    rv[m] = 1'b0;
    n_cmp++;
    if (udf[m] !== 1'b1) begin
      n_bad++;
      $display("FAIL underflow m%0d: got %b exp 1", m, udf[m]);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int m = 0; m < 2; m++) begin
      test_reset(m);
      test_fill_drain(m);
      test_latency(m);
      test_full_rw(m);
      test_thresholds(m);
      test_flush(m);
      test_reset_midburst(m);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1);
  end

endmodule
